// File: rtl/led_request_arbiter_if.sv
// led_request_arbiter_if: requester-side inputs and LED-driver-side outputs of the LED arbiter
interface led_request_arbiter_if;
    logic [2:0] req;
    logic [2:0] pat0;
    logic [2:0] pat1;
    logic [2:0] pat2;
    logic [2:0] cmd;
    logic [2:0] grant;
    logic [2:0] done;
    logic       busy;
    modport master (output req, pat0, pat1, pat2, input cmd, grant, done, busy);
    modport slave (input req, pat0, pat1, pat2, output cmd, grant, done, busy);
endinterface

// File: rtl/led_request_arbiter.sv
// led_request_arbiter: shares a 3-LED bank between an alarm (fixed priority, blinking)
// and two round-robin requesters, holding each grant for a fixed window plus a blank gap.
module led_request_arbiter #(
    parameter int HOLD_CYCLES  = 25000000,
    parameter int BLINK_CYCLES = 12500000,
    parameter int GAP_CYCLES   = 1
) (
    input logic clk,
    input logic reset,
    led_request_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
    localparam logic [31:0] HOLD_LAST  = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
    state_t      r_state, w_state;
    logic [31:0] r_cnt, w_cnt;
    logic [31:0] r_bcnt, w_bcnt;
    logic        r_blank, w_blank;
    logic        r_rr, w_rr;
    logic [1:0]  r_win, w_win;
    logic [2:0]  r_pat, w_pat;
    logic [2:0]  r_cmd, w_cmd;
    logic [2:0]  r_grant, w_grant;
    logic [2:0]  r_done, w_done;
    logic        r_busy, w_busy;
    logic [1:0]  w_sel;
    logic [2:0]  w_sel_pat;
    // r_rr names the preferred requester when 0 and 1 both ask
    assign w_sel = bus.req[2] ? 2'd2 :
                   (bus.req[0] & bus.req[1]) ? {1'b0, r_rr} :
                   bus.req[1] ? 2'd1 : 2'd0;
    assign w_sel_pat = (w_sel == 2'd2) ? bus.pat2 : (w_sel == 2'd1) ? bus.pat1 : bus.pat0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bcnt  <= '0;
            r_blank <= 1'b0;
            r_rr    <= 1'b0;
            r_win   <= 2'd0;
            r_pat   <= 3'b000;
            r_cmd   <= 3'b000;
            r_grant <= 3'b000;
            r_done  <= 3'b000;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bcnt  <= w_bcnt;
            r_blank <= w_blank;
            r_rr    <= w_rr;
            r_win   <= w_win;
            r_pat   <= w_pat;
            r_cmd   <= w_cmd;
            r_grant <= w_grant;
            r_done  <= w_done;
            r_busy  <= w_busy;
        end
    end
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_bcnt  = r_bcnt;
        w_blank = r_blank;
        w_rr    = r_rr;
        w_win   = r_win;
        w_pat   = r_pat;
        w_cmd   = r_cmd;
        w_grant = r_grant;
        w_done  = 3'b000;
        w_busy  = r_busy;
        case (r_state)
            IDLE: begin
                if (|bus.req) begin
                    w_state = SHOW;
                    w_win   = w_sel;
                    w_pat   = w_sel_pat;
                    w_cmd   = w_sel_pat;
                    w_grant = 3'b001 << w_sel;
                    w_busy  = 1'b1;
                    w_cnt   = '0;
                    w_bcnt  = '0;
                    w_blank = 1'b0;
                end
            end
            SHOW: begin
                if (r_cnt == HOLD_LAST) begin
                    w_done  = 3'b001 << r_win;
                    w_grant = 3'b000;
                    w_cmd   = 3'b000;
                    w_cnt   = '0;
                    w_rr    = (r_win == 2'd0) ? 1'b1 : (r_win == 2'd1) ? 1'b0 : r_rr;
                    w_state = (GAP_CYCLES > 0) ? GAP : IDLE;
                    w_busy  = (GAP_CYCLES > 0);
                end else begin
                    w_cnt   = r_cnt + 32'd1;
                    w_bcnt  = (r_bcnt == BLINK_LAST) ? '0 : r_bcnt + 32'd1;
                    w_blank = (r_bcnt == BLINK_LAST) ? ~r_blank : r_blank;
                    w_cmd   = (r_win == 2'd2 && w_blank) ? 3'b000 : r_pat;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state = IDLE;
                    w_busy  = 1'b0;
                end else begin
                    w_cnt = r_cnt + 32'd1;
                end
            end
            default: w_state = IDLE;
        endcase
    end
    assign bus.cmd   = r_cmd;
    assign bus.grant = r_grant;
    assign bus.done  = r_done;
    assign bus.busy  = r_busy;
endmodule

// File: tb/tb_led_request_arbiter.sv
// tb_led_request_arbiter: directed checks of arbitration, blink, gap, latching and reset abort
module tb_led_request_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_err = 0;
    led_request_arbiter_if bus();
    led_request_arbiter #(.HOLD_CYCLES(8), .BLINK_CYCLES(2), .GAP_CYCLES(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got cmd/grant/done/busy=%b expected %b", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic expect_o(input string tag, input logic [2:0] c, input logic [2:0] g,
                            input logic [2:0] d, input logic b);
        check(tag, {bus.cmd, bus.grant, bus.done, bus.busy}, {c, g, d, b});
    endtask
    task automatic do_reset();
        reset = 1'b1;
        tick();
        expect_o("reset", 3'b000, 3'b000, 3'b000, 1'b0);
        reset = 1'b0;
    endtask
    // one full service: grant edge, 8 SHOW cycles, 2 GAP cycles, 1 IDLE cycle
    task automatic window(input string tag, input logic [2:0] g, input logic [2:0] p,
                          input bit blink, input logic [2:0] req_after, input int mid_i,
                          input logic [2:0] mid_req, input logic [2:0] mid_pat0);
        for (int i = 0; i < 8; i++) begin
            tick();
            expect_o($sformatf("%s show%0d", tag, i), (blink && ((i / 2) % 2 == 1)) ? 3'b000 : p,
                     g, 3'b000, 1'b1);
            if (i == mid_i) begin
                bus.req  = mid_req;
                bus.pat0 = mid_pat0;
            end
        end
        tick();
        expect_o({tag, " done"}, 3'b000, 3'b000, g, 1'b1);
        bus.req = req_after;
        tick();
        expect_o({tag, " gap"}, 3'b000, 3'b000, 3'b000, 1'b1);
        tick();
        expect_o({tag, " idle"}, 3'b000, 3'b000, 3'b000, 1'b0);
    endtask
    initial begin
        bus.req = 3'b000;
        bus.pat0 = 3'b000;
        bus.pat1 = 3'b000;
        bus.pat2 = 3'b000;
        do_reset();
        tick();
        expect_o("idle no req", 3'b000, 3'b000, 3'b000, 1'b0);
        bus.req = 3'b001;
        bus.pat0 = 3'b101;
        window("single", 3'b001, 3'b101, 1'b0, 3'b000, -1, 3'b000, 3'b101);
        tick();
        expect_o("single after", 3'b000, 3'b000, 3'b000, 1'b0);
        do_reset();
        bus.req = 3'b011;
        bus.pat0 = 3'b001;
        bus.pat1 = 3'b010;
        window("rr0a", 3'b001, 3'b001, 1'b0, 3'b011, -1, 3'b011, 3'b001);
        window("rr1a", 3'b010, 3'b010, 1'b0, 3'b011, -1, 3'b011, 3'b001);
        window("rr0b", 3'b001, 3'b001, 1'b0, 3'b011, -1, 3'b011, 3'b001);
        window("rr1b", 3'b010, 3'b010, 1'b0, 3'b000, -1, 3'b000, 3'b001);
        do_reset();
        bus.req = 3'b111;
        bus.pat2 = 3'b111;
        window("alarm", 3'b100, 3'b111, 1'b1, 3'b011, -1, 3'b011, 3'b001);
        window("post0", 3'b001, 3'b001, 1'b0, 3'b010, -1, 3'b010, 3'b001);
        window("post1", 3'b010, 3'b010, 1'b0, 3'b000, -1, 3'b000, 3'b001);
        do_reset();
        bus.req = 3'b001;
        bus.pat0 = 3'b101;
        bus.pat2 = 3'b110;
        window("nopre0", 3'b001, 3'b101, 1'b0, 3'b100, 3, 3'b101, 3'b101);
        window("nopre2", 3'b100, 3'b110, 1'b1, 3'b000, -1, 3'b000, 3'b101);
        bus.req = 3'b001;
        bus.pat0 = 3'b101;
        window("latch", 3'b001, 3'b101, 1'b0, 3'b000, 3, 3'b000, 3'b011);
        do_reset();
        bus.req = 3'b010;
        bus.pat1 = 3'b110;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_o($sformatf("pre-abort show%0d", i), 3'b110, 3'b010, 3'b000, 1'b1);
        end
        reset = 1'b1;
        #1;
        expect_o("async abort", 3'b000, 3'b000, 3'b000, 1'b0);
        tick();
        expect_o("held reset", 3'b000, 3'b000, 3'b000, 1'b0);
        reset = 1'b0;
        tick();
        expect_o("regrant", 3'b110, 3'b010, 3'b000, 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
